// File: rtl/display_pkg.sv
// Shared constants, state encoding and helpers for the display scan scheduler.
// The blank values double as reset values for the matrix and digit outputs.
package display_pkg;

    localparam int NUM_SCAN = 8;
    localparam int SCAN_W   = $clog2(NUM_SCAN);

    localparam logic [SCAN_W-1:0] LAST_IDX = 3'd7;

    localparam logic [7:0] BLANK_SEL  = 8'hFF;
    localparam logic [7:0] BLANK_DATA = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Fixed priority: src0 wins over src1 whenever both request.
    function automatic logic [1:0] owner_from_req(input logic [1:0] req_v);
        logic [1:0] st_v;
        if (req_v[0]) begin
            st_v = ST_OWN0;
        end else if (req_v[1]) begin
            st_v = ST_OWN1;
        end else begin
            st_v = ST_IDLE;
        end
        return st_v;
    endfunction

    function automatic logic [1:0] gnt_from_state(input logic [1:0] st_v);
        logic [1:0] g_v;
        case (st_v)
            ST_OWN0: g_v = 2'b01;
            ST_OWN1: g_v = 2'b10;
            default: g_v = 2'b00;
        endcase
        return g_v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Divides the system clock into one tick per scan index; the count freezes while
// scanning is disabled so a resumed scan keeps its phase.
module scan_prescaler #(
    parameter int DIV   = 25000,
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             wrap_s;

    assign wrap_s = (cnt_r == LAST_CNT);
    assign tick   = en & wrap_s;

    // Enabled cycle counter, wraps at DIV-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexes the LED matrix and seven-segment bank over eight scan indices
// and hands display ownership between two sources only at frame boundaries.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int DIV   = 25000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [2:0] scan_idx,
    input  logic [7:0] src0_col,
    input  logic [7:0] src0_seg,
    input  logic [7:0] src1_col,
    input  logic [7:0] src1_seg,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic [7:0] digit_scan,
    output logic [7:0] digit_cath,
    output logic       frame_start
);

    logic       tick_s;
    logic       boundary_s;
    logic [1:0] state_r;
    logic [1:0] state_next_s;
    logic [1:0] gnt_r;
    logic [2:0] scan_idx_r;
    logic [7:0] sel_s;
    logic [7:0] data_col_s;
    logic [7:0] data_seg_s;
    logic [7:0] row_r;
    logic [7:0] col_r;
    logic [7:0] digit_scan_r;
    logic [7:0] digit_cath_r;
    logic       frame_start_r;

    scan_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_scan_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick_s)
    );

    assign boundary_s   = tick_s & (scan_idx_r == LAST_IDX);
    assign state_next_s = owner_from_req(req);
    assign sel_s        = ~(8'h01 << scan_idx_r);

    // Source data mux; the grant is frozen within a frame so no frame mixes sources
    always_comb begin
        data_col_s = BLANK_DATA;
        data_seg_s = BLANK_DATA;
        case (gnt_r)
            2'b01: begin
                data_col_s = src0_col;
                data_seg_s = src0_seg;
            end
            2'b10: begin
                data_col_s = src1_col;
                data_seg_s = src1_seg;
            end
            default: begin
                data_col_s = BLANK_DATA;
                data_seg_s = BLANK_DATA;
            end
        endcase
    end

    // Scan index, arbiter and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gnt_r         <= 2'b00;
            scan_idx_r    <= 3'd0;
            row_r         <= BLANK_SEL;
            col_r         <= BLANK_DATA;
            digit_scan_r  <= BLANK_SEL;
            digit_cath_r  <= BLANK_DATA;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= boundary_s;
            if (!en) begin
                // Blank the pins while the scan is paused; ownership and index hold
                row_r        <= BLANK_SEL;
                col_r        <= BLANK_DATA;
                digit_scan_r <= BLANK_SEL;
                digit_cath_r <= BLANK_DATA;
            end else if (tick_s) begin
                row_r        <= sel_s;
                digit_scan_r <= sel_s;
                col_r        <= data_col_s;
                digit_cath_r <= data_seg_s;
                scan_idx_r   <= scan_idx_r + 3'd1;
                if (boundary_s) begin
                    state_r <= state_next_s;
                    gnt_r   <= gnt_from_state(state_next_s);
                end else begin
                    state_r <= state_r;
                    gnt_r   <= gnt_r;
                end
            end else begin
                row_r        <= row_r;
                col_r        <= col_r;
                digit_scan_r <= digit_scan_r;
                digit_cath_r <= digit_cath_r;
            end
        end
    end

    assign gnt         = gnt_r;
    assign scan_idx    = scan_idx_r;
    assign row         = row_r;
    assign col         = col_r;
    assign digit_scan  = digit_scan_r;
    assign digit_cath  = digit_cath_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a count-based behavioural model.
module tb_display_scan_scheduler;

    localparam int DIV   = 4;
    localparam int CNT_W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic [2:0] scan_idx;
    logic [7:0] src0_col, src0_seg, src1_col, src1_seg;
    logic [7:0] row, col, digit_scan, digit_cath;
    logic       frame_start;

    logic [7:0] b0c = 8'hA5, b0s = 8'h3C, b1c = 8'h5A, b1s = 8'hC3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    display_scan_scheduler #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .gnt(gnt), .scan_idx(scan_idx),
        .src0_col(src0_col), .src0_seg(src0_seg), .src1_col(src1_col), .src1_seg(src1_seg),
        .row(row), .col(col), .digit_scan(digit_scan), .digit_cath(digit_cath),
        .frame_start(frame_start)
    );

    // Index-dependent source content; index 0 shows the base pattern itself
    function automatic logic [7:0] mix(input logic [7:0] b, input logic [2:0] i);
        return b + 8'(i) * 8'd37;
    endfunction

    always_comb begin
        src0_col = mix(b0c, scan_idx);
        src0_seg = mix(b0s, scan_idx);
        src1_col = mix(b1c, scan_idx);
        src1_seg = mix(b1s, scan_idx);
    end

    // Model: scan position derived from the number of enabled cycles since reset
    int unsigned m_e    = 0;
    logic [1:0]  m_gnt  = 2'b00;
    logic [7:0]  m_row  = 8'hFF, m_col = 8'h00, m_cath = 8'h00;
    logic        m_fs   = 1'b0;
    logic [2:0]  m_idx;
    logic        m_tick;

    assign m_idx  = 3'((m_e / DIV) % 8);
    assign m_tick = en && ((m_e % DIV) == DIV - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_e <= 0; m_gnt <= 2'b00; m_row <= 8'hFF; m_col <= 8'h00; m_cath <= 8'h00; m_fs <= 1'b0;
        end else begin
            m_fs <= m_tick && (m_idx == 3'd7);
            if (!en) begin
                m_row <= 8'hFF; m_col <= 8'h00; m_cath <= 8'h00;
            end else begin
                m_e <= (m_e + 1) % (8 * DIV);
                if (m_tick) begin
                    m_row  <= ~(8'h01 << m_idx);
                    m_col  <= (m_gnt == 2'b01) ? mix(b0c, m_idx) : (m_gnt == 2'b10) ? mix(b1c, m_idx) : 8'h00;
                    m_cath <= (m_gnt == 2'b01) ? mix(b0s, m_idx) : (m_gnt == 2'b10) ? mix(b1s, m_idx) : 8'h00;
                    if (m_idx == 3'd7)
                        m_gnt <= req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        n_tests++;
        if (gnt !== m_gnt || scan_idx !== m_idx || row !== m_row || digit_scan !== m_row ||
            col !== m_col || digit_cath !== m_cath || frame_start !== m_fs) begin
            n_fail++;
            $display("FAIL model t=%0t gnt=%b/%b idx=%0d/%0d row=%h/%h dscan=%h col=%h/%h cath=%h/%h fs=%b/%b",
                     $time, gnt, m_gnt, scan_idx, m_idx, row, m_row, digit_scan, col, m_col,
                     digit_cath, m_cath, frame_start, m_fs);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_idx(input logic [2:0] v);
        bit hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (scan_idx == v) hit = 1'b1;
        end
        if (!hit) check("wait_idx_timeout", 8'h00, 8'h01);
    endtask

    task automatic wait_sig(input string name, input int which, input logic [7:0] v);
        bit hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            case (which)
                0: hit = (frame_start == v[0]);
                1: hit = (row == v);
                default: hit = ({6'd0, gnt} == v);
            endcase
        end
        if (!hit) check(name, 8'h00, 8'h01);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_row", row, 8'hFF);
        check("reset_dscan", digit_scan, 8'hFF);
        check("reset_col", col, 8'h00);
        check("reset_gnt", {6'd0, gnt}, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_tick_row", row, 8'hFF);
        @(negedge clk);
        check("first_tick_row", row, 8'hFE);
        check("first_tick_col", col, 8'h00);
        check("first_tick_idx", {5'd0, scan_idx}, 8'h01);

        req = 2'b01;
        @(negedge clk);
        check("gnt_frozen", {6'd0, gnt}, 8'h00);
        wait_sig("wait_frame_start", 0, 8'h01);
        check("gnt_after_boundary", {6'd0, gnt}, 8'h01);
        wait_sig("wait_row_fe", 1, 8'hFE);
        check("own0_col", col, 8'hA5);
        check("own0_cath", digit_cath, 8'h3C);

        wait_idx(3'd5);
        en = 1'b0;
        @(negedge clk);
        check("pause_row", row, 8'hFF);
        check("pause_dscan", digit_scan, 8'hFF);
        check("pause_col", col, 8'h00);
        repeat (9) @(negedge clk);
        check("pause_idx", {5'd0, scan_idx}, 8'h05);
        check("pause_gnt", {6'd0, gnt}, 8'h01);
        en = 1'b1;

        req = 2'b10;
        wait_sig("wait_gnt10", 2, 8'h02);
        wait_idx(3'd6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_gnt", {6'd0, gnt}, 8'h00);
        check("midrst_idx", {5'd0, scan_idx}, 8'h00);
        check("midrst_row", row, 8'hFF);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom % 40 == 0) req = 2'($urandom);
            if ($urandom % 50 == 0) begin
                b0c = 8'($urandom); b0s = 8'($urandom);
                b1c = 8'($urandom); b1s = 8'($urandom);
            end
            if (en && ($urandom % 80 == 0)) en = 1'b0;
            else if (!en && ($urandom % 6 == 0)) en = 1'b1;
            rst = ($urandom % 700 == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Owns the shared 8x8 LED matrix (row/col) and the 8-digit seven-segment bank (digit_scan/digit_cath) of the selecting machine.
- Time-multiplexes both displays over 8 scan indices.
- Arbitrates display ownership between two content sources: src0, the startup/self-test pattern generator, which has priority, and src1, the selection menu.
- Ownership changes only at frame boundaries, so a frame is never torn between sources.

Parameters:
- DIV, 25000, clk cycles per scan index. At 50 MHz this gives 2 kHz per index and a 250 Hz frame. Legal range 1..2^20.
- CNT_W, 20, prescaler width. Must satisfy 2^CNT_W >= DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  scan enable, driven from board switch sw
- req  input  2  per-source request; bit0 = src0, bit1 = src1
- gnt  output  2  one-hot (or zero) grant, registered
- scan_idx  output  3  index whose data the sources must present combinationally this cycle
- src0_col  input  8  src0 matrix column data for scan_idx, active-high
- src0_seg  input  8  src0 segment pattern for scan_idx, active-high
- src1_col  input  8  src1 matrix column data for scan_idx, active-high
- src1_seg  input  8  src1 segment pattern for scan_idx, active-high
- row  output  8  matrix row select, active-low one-hot
- col  output  8  matrix column drive, active-high
- digit_scan  output  8  digit select, active-low one-hot
- digit_cath  output  8  segment drive, active-high
- frame_start  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values (rst=1 at a clk edge):
  - prescaler=0, scan_idx=0, gnt=2'b00, state=IDLE, frame_start=0
  - row=8'hFF, col=8'h00, digit_scan=8'hFF, digit_cath=8'h00
- Reset mid-frame discards the partial frame. No output glitches beyond the reset values.
- Prescaler:
  - Counts only while en=1. On reaching DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - DIV=1 gives a tick every enabled cycle.
- On tick:
  - row <= ~(8'h01<<scan_idx); digit_scan <= same value.
  - col/digit_cath <= data of the granted source, or 8'h00 if gnt=0.
  - scan_idx <= scan_idx+1, wrapping 7 -> 0.
  - Display latency is 1 cycle from scan_idx to the driven row.
- Frame boundary = a tick with scan_idx==7. At that edge:
  - The arbiter updates state/gnt.
  - frame_start=1 for exactly the following cycle.
  - The new grant first affects data latched at scan_idx=0.
- FSM states: IDLE (gnt=00), OWN0 (gnt=01), OWN1 (gnt=10). Evaluated only at frame boundaries:
  - req[0]=1 -> OWN0. Fixed priority; src0 preempts src1 at the boundary.
  - else req[1]=1 -> OWN1
  - else -> IDLE
- Between boundaries:
  - gnt is frozen.
  - A req change is not seen until the next boundary.
  - A granted source that drops req still owns the display (and blank-free data is its responsibility) until the boundary.
- Simultaneous req=2'b11 -> src0 wins. src1 waits, with no starvation guarantee while src0 holds req.
- en=0:
  - Prescaler and scan_idx hold.
  - Outputs are forced to their blank reset values on the next edge.
  - gnt and state hold.
- en re-asserted: scan resumes from the held scan_idx. The prescaler restarts its count from the held value.
- The sources' data must be combinational from scan_idx. The block registers it, so no combinational path runs from src data to the pins.

Decomposition:
- Package display_pkg:
  - state encoding IDLE/OWN0/OWN1
  - NUM_SCAN=8
  - BLANK_SEL=8'hFF, BLANK_DATA=8'h00
- Sub-module scan_prescaler(clk, rst, en, tick) holds the DIV counter. Arbiter FSM, index counter and output registers stay in display_scan_scheduler.

Test Plan:
- DIV=4, rst held 3 cycles then released, en=1, req=00 -> first tick on cycle 4 after release. Outputs step through row=FE,FD,...,7F with col=00, and frame_start pulses every 32 cycles.
- req=01 asserted mid-frame, src0_col=8'hA5 -> gnt stays 00 until the boundary tick, then gnt=01, frame_start=1 the next cycle. The next row=FE drives col=A5.
- Owner src1 (gnt=10), req goes 11 at scan_idx=3 -> gnt stays 10 through scan_idx 7, then gnt=01 at the boundary. No frame mixes src0/src1 data.
- Owner src0, req drops to 00 at scan_idx=2 -> src0 data is still shown for rows 2..7. At the boundary gnt=00, and the next frame shows col=00, digit_cath=00.
- en deasserted at scan_idx=5 for 10 cycles -> the next edge gives row=FF, digit_scan=FF, col=00. scan_idx holds at 5, then resumes at 5 with the same gnt.
- rst pulsed 1 cycle at scan_idx=6 with gnt=10 -> the next cycle shows all reset values (gnt=00, scan_idx=0, row=FF). The frame restarts cleanly.
